// File: rtl/adder_bist.sv
// ---------------------------------------------------------------------------
// adder_bist
//
// Purpose: built-in self-test engine for a combinational adder. It drives
// pseudo-random operands (two 32-bit Galois LFSRs) into the adder and
// registers the adder's sum and carry-out. It then compares the result with
// an internally computed reference. It reports pass/fail, a saturating error
// count and the first failing vector.
//
// Optional feature: define ADDER_BIST_CORNER_EN to run four fixed corner
// vectors before the LFSR vectors. The LFSRs hold during the corners.
//
// Parameters:
//   WIDTH    operand width, 1..32
//   NUM_VEC  pseudo-random vectors per run, 0..65535
//   SEED     LFSR A seed; LFSR B uses ~SEED; a zero seed becomes 32'h1
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, honoured only in IDLE or DONE
//   a_out, b_out        operands driven to the adder
//   ci_out              carry-in driven to the adder
//   s_in, co_in         adder sum and carry-out
//   busy                run in progress (GEN/WAIT/CHECK)
//   done                run finished; held until the next start or reset
//   pass                done with zero mismatches
//   err_cnt             mismatch count, saturating at 16'hFFFF
//   fail_vld            a first-failure record has been captured
//   fail_a/b/ci         operands of the first mismatching vector
//   fail_sum            {co,s} observed at the first mismatch
// ---------------------------------------------------------------------------
module adder_bist #(
  parameter int          WIDTH   = 32,
  parameter int          NUM_VEC = 10,
  parameter logic [31:0] SEED    = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             ci_out,
  input  logic [WIDTH-1:0] s_in,
  input  logic             co_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_cnt,
  output logic             fail_vld,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_ci,
  output logic [WIDTH:0]   fail_sum
);

  // Run length, including the corner vectors when they are enabled.
`ifdef ADDER_BIST_CORNER_EN
  localparam int NUM_CORNER = 4;
`else
  localparam int NUM_CORNER = 0;
`endif
  localparam logic [16:0] TOTAL_VEC = 17'(NUM_VEC + NUM_CORNER);

  // Seeds with the all-zero lock-up state excluded.
  localparam logic [31:0] SEED_B_RAW = ~SEED;
  localparam logic [31:0] SEED_A     = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] SEED_B     = (SEED_B_RAW == 32'h0) ? 32'h1 : SEED_B_RAW;
  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [31:0]      r_lfsrA;
  logic [31:0]      r_lfsrB;
  logic [16:0]      r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_ci;
  logic [WIDTH-1:0] r_sQ;
  logic             r_coQ;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_errCnt;
  logic             r_failVld;
  logic [WIDTH-1:0] r_failA;
  logic [WIDTH-1:0] r_failB;
  logic             r_failCi;
  logic [WIDTH:0]   r_failSum;

  logic [31:0]      w_lfsrANext;
  logic [31:0]      w_lfsrBNext;
  logic [WIDTH-1:0] w_genA;
  logic [WIDTH-1:0] w_genB;
  logic             w_genCi;
  logic             w_genAdvance;
  logic [WIDTH:0]   w_expSum;
  logic             w_mismatch;
  logic [15:0]      w_errNext;
  logic [16:0]      w_idxNext;

  // One Galois step per LFSR: shift right, fold in the mask on a shifted-out one.
  assign w_lfsrANext = {1'b0, r_lfsrA[31:1]} ^ (r_lfsrA[0] ? LFSR_MASK : 32'h0);
  assign w_lfsrBNext = {1'b0, r_lfsrB[31:1]} ^ (r_lfsrB[0] ? LFSR_MASK : 32'h0);

  // Vector selection for the GEN state: corners first (when enabled), then
  // LFSR vectors. The LFSRs only advance when an LFSR vector is issued.
`ifdef ADDER_BIST_CORNER_EN
  localparam logic [31:0]      PAT55 = 32'h5555_5555;
  localparam logic [31:0]      PATAA = 32'hAAAA_AAAA;
  localparam logic [WIDTH-1:0] ONES  = '1;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  always_comb begin
    w_genA       = r_lfsrA[WIDTH-1:0];
    w_genB       = r_lfsrB[WIDTH-1:0];
    w_genCi      = r_lfsrA[31] ^ r_lfsrB[0];
    w_genAdvance = 1'b1;
    if (r_idx < 17'd4) begin
      w_genAdvance = 1'b0;
      case (r_idx[1:0])
        2'd0:    begin w_genA = '0;                 w_genB = '0;                 w_genCi = 1'b0; end
        2'd1:    begin w_genA = ONES;               w_genB = ONE;                w_genCi = 1'b0; end
        2'd2:    begin w_genA = ONES;               w_genB = ONES;               w_genCi = 1'b1; end
        default: begin w_genA = PAT55[WIDTH-1:0];   w_genB = PATAA[WIDTH-1:0];   w_genCi = 1'b1; end
      endcase
    end
  end
`else
  always_comb begin
    w_genA       = r_lfsrA[WIDTH-1:0];
    w_genB       = r_lfsrB[WIDTH-1:0];
    w_genCi      = r_lfsrA[31] ^ r_lfsrB[0];
    w_genAdvance = 1'b1;
  end
`endif

  // Reference sum is WIDTH+1 bits so the carry-out is checked as well.
  assign w_expSum   = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_ci};
  assign w_mismatch = (w_expSum != {r_coQ, r_sQ});
  assign w_errNext  = (w_mismatch && (r_errCnt != 16'hFFFF)) ? r_errCnt + 16'd1 : r_errCnt;
  assign w_idxNext  = r_idx + 17'd1;

  // Main sequencer. All outputs are registered here. Each vector takes
  // GEN (drive), WAIT (capture adder result), CHECK (compare).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lfsrA   <= SEED_A;
      r_lfsrB   <= SEED_B;
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_ci      <= 1'b0;
      r_sQ      <= '0;
      r_coQ     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_errCnt  <= '0;
      r_failVld <= 1'b0;
      r_failA   <= '0;
      r_failB   <= '0;
      r_failCi  <= 1'b0;
      r_failSum <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_lfsrA   <= SEED_A;
            r_lfsrB   <= SEED_B;
            r_idx     <= '0;
            r_errCnt  <= '0;
            r_failVld <= 1'b0;
            r_failA   <= '0;
            r_failB   <= '0;
            r_failCi  <= 1'b0;
            r_failSum <= '0;
            if (TOTAL_VEC == 17'd0) begin
              // Empty run: nothing to test, finish immediately as a pass.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_GEN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
        end
        S_GEN: begin
          r_a  <= w_genA;
          r_b  <= w_genB;
          r_ci <= w_genCi;
          if (w_genAdvance) begin
            r_lfsrA <= w_lfsrANext;
            r_lfsrB <= w_lfsrBNext;
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_sQ    <= s_in;
          r_coQ   <= co_in;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_errCnt <= w_errNext;
          if (w_mismatch && !r_failVld) begin
            r_failVld <= 1'b1;
            r_failA   <= r_a;
            r_failB   <= r_b;
            r_failCi  <= r_ci;
            r_failSum <= {r_coQ, r_sQ};
          end
          r_idx <= w_idxNext;
          if (w_idxNext == TOTAL_VEC) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_errNext == 16'd0);
          end else begin
            r_state <= S_GEN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign a_out    = r_a;
  assign b_out    = r_b;
  assign ci_out   = r_ci;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_errCnt;
  assign fail_vld = r_failVld;
  assign fail_a   = r_failA;
  assign fail_b   = r_failB;
  assign fail_ci  = r_failCi;
  assign fail_sum = r_failSum;

endmodule

// File: tb/tb_adder_bist.sv
// ---------------------------------------------------------------------------
// tb_adder_bist
//
// Bench for adder_bist (default build, corner vectors disabled). The adder
// under test is modelled here. A fault selector turns it into a correct
// adder, an adder with sum bit 0 inverted, or an adder with carry-out stuck
// at 0. Expected operand values are hand-computed from the LFSR definition
// starting at SEED = 1:
//   vector 0: a=0000_0001 b=FFFF_FFFE ci=0
//   vector 1: a=8020_0003 b=7FFF_FFFF ci=0
//   vector 2: a=C030_0002 b=BFDF_FFFC ci=1
// ---------------------------------------------------------------------------
module tb_adder_bist;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             ci_out;
  logic [WIDTH-1:0] s_in;
  logic             co_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_cnt;
  logic             fail_vld;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic             fail_ci;
  logic [WIDTH:0]   fail_sum;

  int               faultMode;
  int               checks;
  int               errors;
  logic [WIDTH:0]   adderSum;

  adder_bist #(
    .WIDTH  (WIDTH),
    .NUM_VEC(10),
    .SEED   (32'h0000_0001)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_out   (a_out),
    .b_out   (b_out),
    .ci_out  (ci_out),
    .s_in    (s_in),
    .co_in   (co_in),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .fail_vld(fail_vld),
    .fail_a  (fail_a),
    .fail_b  (fail_b),
    .fail_ci (fail_ci),
    .fail_sum(fail_sum)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test with selectable fault.
  always_comb begin
    adderSum = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, ci_out};
    if (faultMode == 1) adderSum[0] = ~adderSum[0];
    if (faultMode == 2) adderSum[WIDTH] = 1'b0;
  end
  assign s_in  = adderSum[WIDTH-1:0];
  assign co_in = adderSum[WIDTH];

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Pulse start for one edge; returns 1 time unit after the sampling edge e0.
  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until done is seen, bounded so the bench cannot hang.
  task automatic waitDone(input string tag, input int expected);
    int cnt;
    cnt = 0;
    while (!done && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput(tag, 64'(cnt), 64'(expected));
  endtask

  task automatic checkVector(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ci);
    checkOutput({tag, "_a"},  64'(a_out),  64'(a));
    checkOutput({tag, "_b"},  64'(b_out),  64'(b));
    checkOutput({tag, "_ci"}, 64'(ci_out), 64'(ci));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_a"},       64'(a_out),    64'h0);
    checkOutput({tag, "_b"},       64'(b_out),    64'h0);
    checkOutput({tag, "_ci"},      64'(ci_out),   64'h0);
    checkOutput({tag, "_busy"},    64'(busy),     64'h0);
    checkOutput({tag, "_done"},    64'(done),     64'h0);
    checkOutput({tag, "_pass"},    64'(pass),     64'h0);
    checkOutput({tag, "_errCnt"},  64'(err_cnt),  64'h0);
    checkOutput({tag, "_failVld"}, 64'(fail_vld), 64'h0);
    checkOutput({tag, "_failA"},   64'(fail_a),   64'h0);
    checkOutput({tag, "_failB"},   64'(fail_b),   64'h0);
    checkOutput({tag, "_failCi"},  64'(fail_ci),  64'h0);
    checkOutput({tag, "_failSum"}, 64'(fail_sum), 64'h0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    faultMode = 0;
    start     = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #20;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Run 1: correct adder, operand sequence and 30-cycle latency.
    $display("[TB] run 1: correct adder");
    applyStimulus();
    checkOutput("r1_busy", 64'(busy), 64'h1);
    stepCycles(1);
    checkVector("r1_v0", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    stepCycles(3);
    checkVector("r1_v1", 32'h8020_0003, 32'h7FFF_FFFF, 1'b0);
    stepCycles(3);
    checkVector("r1_v2", 32'hC030_0002, 32'hBFDF_FFFC, 1'b1);
    waitDone("r1_latency", 23);
    checkOutput("r1_busyLow", 64'(busy),     64'h0);
    checkOutput("r1_errCnt",  64'(err_cnt),  64'h0);
    checkOutput("r1_pass",    64'(pass),     64'h1);
    checkOutput("r1_failVld", 64'(fail_vld), 64'h0);

    // Run 2: sum bit 0 inverted, every vector fails.
    $display("[TB] run 2: sum bit 0 inverted");
    faultMode = 1;
    applyStimulus();
    checkOutput("r2_doneLow", 64'(done), 64'h0);
    waitDone("r2_latency", 30);
    checkOutput("r2_errCnt",  64'(err_cnt),  64'd10);
    checkOutput("r2_failVld", 64'(fail_vld), 64'h1);
    checkOutput("r2_failA",   64'(fail_a),   64'h0000_0001);
    checkOutput("r2_failB",   64'(fail_b),   64'hFFFF_FFFE);
    checkOutput("r2_failCi",  64'(fail_ci),  64'h0);
    checkOutput("r2_failSum", 64'(fail_sum), 64'h0_FFFF_FFFE);
    checkOutput("r2_pass",    64'(pass),     64'h0);

    // Run 3: back-to-back from DONE, results clear, sequence replays,
    // a start pulse mid-run is ignored.
    $display("[TB] run 3: back-to-back replay with ignored start");
    faultMode = 0;
    applyStimulus();
    checkOutput("r3_errClr",  64'(err_cnt),  64'h0);
    checkOutput("r3_vldClr",  64'(fail_vld), 64'h0);
    stepCycles(1);
    checkVector("r3_v0", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    stepCycles(3);
    checkVector("r3_v1", 32'h8020_0003, 32'h7FFF_FFFF, 1'b0);
    start = 1'b1;
    stepCycles(1);
    start = 1'b0;
    checkOutput("r3_busyMid", 64'(busy), 64'h1);
    waitDone("r3_latency", 25);
    checkOutput("r3_pass", 64'(pass), 64'h1);

    // Run 4: asynchronous reset in the middle of a failing run.
    $display("[TB] run 4: reset mid-run");
    faultMode = 1;
    applyStimulus();
    stepCycles(12);
    #2 rst_n = 1'b0;
    #1;
    checkResetState("midReset");
    @(negedge clk);
    rst_n     = 1'b1;
    faultMode = 0;
    applyStimulus();
    waitDone("r4_latency", 30);
    checkOutput("r4_pass",   64'(pass),    64'h1);
    checkOutput("r4_errCnt", 64'(err_cnt), 64'h0);

    // Run 5: carry-out stuck at 0; vector 0 has no carry, vector 1 does.
    $display("[TB] run 5: carry-out stuck at 0");
    faultMode = 2;
    applyStimulus();
    waitDone("r5_latency", 30);
    checkOutput("r5_errNonZero", 64'(err_cnt != 16'd0), 64'h1);
    checkOutput("r5_failVld", 64'(fail_vld), 64'h1);
    checkOutput("r5_failA",   64'(fail_a),   64'h8020_0003);
    checkOutput("r5_failB",   64'(fail_b),   64'h7FFF_FFFF);
    checkOutput("r5_failCi",  64'(fail_ci),  64'h0);
    checkOutput("r5_failSum", 64'(fail_sum), 64'h0_0020_0002);
    checkOutput("r5_pass",    64'(pass),     64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
